// File: rtl/branch_predictor_pkg.sv
// Shared constants and width helpers for the branch predictor.
package branch_predictor_pkg;

  // 2-bit saturating counter states
  localparam logic [1:0] SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] WT  = 2'b10;  // weak taken
  localparam logic [1:0] ST  = 2'b11;  // strong taken

  localparam logic [1:0] CTR_RST   = WNT;  // counter value after reset
  localparam logic [1:0] CTR_ALLOC = WT;   // counter value on allocation

  // Number of index bits for a power-of-two table of nentry entries (2..256)
  function automatic int unsigned idx_width(input int unsigned nentry);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 9; i++) begin
      if ((32'd1 << i) < nentry) w = i + 1;
    end
    return w;
  endfunction

  // Tag covers pc[31:idx_width+2]
  function automatic int unsigned tag_width(input int unsigned nentry);
    return 30 - idx_width(nentry);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, update and statistics signals of the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned CW = 16
);
  logic [31:0]   lk_pc;
  logic          lk_hit;
  logic          lk_taken;
  logic [31:0]   lk_target;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic          upd_pred_taken;
  logic          stats_clr;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] mis_cnt;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, stats_clr,
    input  lk_hit, lk_taken, lk_target, br_cnt, mis_cnt
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, stats_clr,
    output lk_hit, lk_taken, lk_target, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  // Step toward strong-taken on taken, toward strong-not-taken otherwise
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters and
// branch/misprediction statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned NENTRY = 16,
  parameter int unsigned CW     = 16
) (
  input logic                clk,
  input logic                rst_n,
  branch_predictor_if.slave  bp
);

  localparam int unsigned IW = idx_width(NENTRY);
  localparam int unsigned TW = tag_width(NENTRY);

  logic          valid_q [NENTRY];
  logic          valid_d [NENTRY];
  logic [TW-1:0] tag_q   [NENTRY];
  logic [TW-1:0] tag_d   [NENTRY];
  logic [1:0]    ctr_q   [NENTRY];
  logic [1:0]    ctr_d   [NENTRY];
  logic [31:0]   tgt_q   [NENTRY];
  logic [31:0]   tgt_d   [NENTRY];

  logic [CW-1:0] br_q, br_d;
  logic [CW-1:0] mis_q, mis_d;

  logic [IW-1:0] lk_idx, up_idx;
  logic [TW-1:0] lk_tag, up_tag;
  logic          lk_hit, up_hit;
  logic [1:0]    ctr_cur, ctr_nxt;
  logic          unused_pc_bits;

  assign lk_idx = bp.lk_pc[IW+1:2];
  assign lk_tag = bp.lk_pc[31:IW+2];
  assign up_idx = bp.upd_pc[IW+1:2];
  assign up_tag = bp.upd_pc[31:IW+2];
  assign unused_pc_bits = ^{bp.lk_pc[1:0], bp.upd_pc[1:0]};

  // Combinational lookup from registered table (no update bypass)
  always_comb begin
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bp.lk_hit    = lk_hit;
    bp.lk_taken  = lk_hit && ctr_q[lk_idx][1];
    bp.lk_target = lk_hit ? tgt_q[lk_idx] : '0;
  end

  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign ctr_cur = ctr_q[up_idx];

  sat_counter2 u_ctr (
    .cnt_i   (ctr_cur),
    .taken_i (bp.upd_taken),
    .cnt_o   (ctr_nxt)
  );

  // Table next state: step on hit, allocate on taken miss, ignore not-taken miss
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    tgt_d   = tgt_q;
    if (bp.upd_valid) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr_nxt;
        if (bp.upd_taken) tgt_d[up_idx] = bp.upd_target;
      end else if (bp.upd_taken) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        ctr_d[up_idx]   = CTR_ALLOC;
        tgt_d[up_idx]   = bp.upd_target;
      end
    end
  end

  // Table registers; flops so reset clears every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NENTRY; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_RST;
        tgt_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      ctr_q   <= ctr_d;
      tgt_q   <= tgt_d;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (bp.stats_clr) begin
      br_d  = '0;
      mis_d = '0;
    end else if (bp.upd_valid) begin
      if (br_q != '1) br_d = br_q + 1'b1;
      if ((bp.upd_taken != bp.upd_pred_taken) && (mis_q != '1)) mis_d = mis_q + 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

  assign bp.br_cnt  = br_q;
  assign bp.mis_cnt = mis_q;

endmodule
